// File: rtl/ev22_exec.sv
// EV22 execute stage: three general registers, a single-cycle ALU with status flags,
// and a side-load port for initialising the registers before a program runs.
module ev22_exec #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [1:0]       sel_a,
   input  logic [1:0]       sel_b,
   input  logic [3:0]       alu,
   input  logic             save0,
   input  logic             save1,
   input  logic             save2,
   input  logic             ld_en,
   input  logic [1:0]       ld_sel,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] reg0,
   output logic [WIDTH-1:0] reg1,
   output logic [WIDTH-1:0] reg2,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             illegal,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             ld_drop
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] res;
   logic             cnew;
   logic             vnew;
   logic             legal;
   logic             flagop;
   logic             exec;
   logic             doload;

   // Operand selection reads the current (pre-write) register contents.
   always_comb begin
      opa = '0;
      case (sel_a)
         2'd0:    opa = reg0;
         2'd1:    opa = reg1;
         2'd2:    opa = reg2;
         default: opa = '0;
      endcase
      opb = '0;
      case (sel_b)
         2'd0:    opb = reg0;
         2'd1:    opb = reg1;
         2'd2:    opb = reg2;
         default: opb = '0;
      endcase
   end

   // Arithmetic runs one bit wider so the top bit carries the carry or borrow.
   always_comb begin
      ext  = '0;
      cnew = 1'b0;
      vnew = 1'b0;
      case (alu)
         4'h0: ext = {1'b0, opa};
         4'h1: ext = {1'b0, opb};
         4'h2: begin
            ext  = {1'b0, opa} + {1'b0, opb};
            cnew = ext[WIDTH];
            vnew = (opa[MSB] == opb[MSB]) && (ext[MSB] != opa[MSB]);
         end
         4'h3: begin
            ext  = {1'b0, opa} - {1'b0, opb};
            cnew = ext[WIDTH];
            vnew = (opa[MSB] != opb[MSB]) && (ext[MSB] != opa[MSB]);
         end
         4'h4: begin
            ext  = {1'b0, opa} + {1'b0, ONE};
            cnew = ext[WIDTH];
            vnew = !opa[MSB] && ext[MSB];
         end
         4'h5: begin
            ext  = {1'b0, opa} - {1'b0, ONE};
            cnew = ext[WIDTH];
            vnew = opa[MSB] && !ext[MSB];
         end
         4'h6:    ext = {1'b0, opa & opb};
         4'h7:    ext = {1'b0, opa | opb};
         4'h8:    ext = {1'b0, opa ^ opb};
         4'h9:    ext = {1'b0, ~opa};
         default: ext = '0;
      endcase
      res = ext[WIDTH-1:0];
   end

   assign legal  = (alu <= 4'h9);
   assign flagop = legal && (alu >= 4'h2);
   assign exec   = in_valid && legal;
   assign doload = ld_en && !in_valid;

   // A valid instruction always wins over a side-load in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg0      <= '0;
         reg1      <= '0;
         reg2      <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         ld_drop   <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         illegal   <= in_valid && !legal;
         ld_drop   <= ld_en && in_valid;
         if (in_valid)
            result <= legal ? res : '0;
         if (exec) begin
            if (save0) reg0 <= res;
            if (save1) reg1 <= res;
            if (save2) reg2 <= res;
         end else if (doload) begin
            if (ld_sel == 2'd0) reg0 <= ld_data;
            if (ld_sel == 2'd1) reg1 <= ld_data;
            if (ld_sel == 2'd2) reg2 <= ld_data;
         end
         if (in_valid && flagop) begin
            flag_z <= (res == '0);
            flag_c <= cnew;
            flag_v <= vnew;
         end
      end
   end

endmodule

// File: tb/tb_ev22_exec.sv
// Directed bench for ev22_exec: hand-computed vectors applied in sequence,
// each output compared with an immediate assertion one cycle after issue.
module tb_ev22_exec;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic [3:0] alu;
   logic       save0;
   logic       save1;
   logic       save2;
   logic       ld_en;
   logic [1:0] ld_sel;
   logic [7:0] ld_data;
   logic [7:0] reg0;
   logic [7:0] reg1;
   logic [7:0] reg2;
   logic [7:0] result;
   logic       out_valid;
   logic       illegal;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;
   logic       ld_drop;

   int vectors = 0;
   int miscompares = 0;

   ev22_exec #(.WIDTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .sel_a(sel_a),
      .sel_b(sel_b),
      .alu(alu),
      .save0(save0),
      .save1(save1),
      .save2(save2),
      .ld_en(ld_en),
      .ld_sel(ld_sel),
      .ld_data(ld_data),
      .reg0(reg0),
      .reg1(reg1),
      .reg2(reg2),
      .result(result),
      .out_valid(out_valid),
      .illegal(illegal),
      .flag_z(flag_z),
      .flag_c(flag_c),
      .flag_v(flag_v),
      .ld_drop(ld_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's worth of inputs, then sample just after the capturing edge.
   task automatic applyStimulus(input logic iv, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [3:0] op, input logic s0, input logic s1,
                                input logic s2, input logic le, input logic [1:0] ls,
                                input logic [7:0] ld);
      in_valid = iv;
      sel_a    = sa;
      sel_b    = sb;
      alu      = op;
      save0    = s0;
      save1    = s1;
      save2    = s2;
      ld_en    = le;
      ld_sel   = ls;
      ld_data  = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkFlags(input string tag, input logic z, input logic c, input logic v);
      checkOutput({tag, "_z"}, 32'(flag_z), 32'(z));
      checkOutput({tag, "_c"}, 32'(flag_c), 32'(c));
      checkOutput({tag, "_v"}, 32'(flag_v), 32'(v));
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting ev22_exec directed run");
      reset = 1'b1;
      applyStimulus(1, 2'd0, 2'd1, 4'h4, 1, 1, 1, 1, 2'd0, 8'h55);
      applyStimulus(1, 2'd0, 2'd1, 4'h4, 1, 1, 1, 1, 2'd1, 8'h66);
      reset = 1'b0;
      checkOutput("rst_reg0", 32'(reg0), 32'h00);
      checkOutput("rst_reg1", 32'(reg1), 32'h00);
      checkOutput("rst_reg2", 32'(reg2), 32'h00);
      checkOutput("rst_result", 32'(result), 32'h00);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_illegal", 32'(illegal), 32'h0);
      checkOutput("rst_ld_drop", 32'(ld_drop), 32'h0);
      checkFlags("rst", 0, 0, 0);

      // Side-load REG0=05, REG1=03 then add into REG2.
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd0, 8'h05);
      checkOutput("ld_out_valid", 32'(out_valid), 32'h0);
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd1, 8'h03);
      checkOutput("ld_reg0", 32'(reg0), 32'h05);
      checkOutput("ld_reg1", 32'(reg1), 32'h03);
      applyStimulus(1, 2'd0, 2'd1, 4'h2, 0, 0, 1, 0, 2'd0, 8'h00);
      checkOutput("add_reg2", 32'(reg2), 32'h08);
      checkOutput("add_result", 32'(result), 32'h08);
      checkOutput("add_out_valid", 32'(out_valid), 32'h1);
      checkOutput("add_illegal", 32'(illegal), 32'h0);
      checkFlags("add", 0, 0, 0);
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
      checkOutput("idle_out_valid", 32'(out_valid), 32'h0);
      checkOutput("idle_result_held", 32'(result), 32'h08);

      // Increment wraps 0xFF to 0x00 with carry.
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd0, 8'hFF);
      applyStimulus(1, 2'd0, 2'd0, 4'h4, 1, 0, 0, 0, 2'd0, 8'h00);
      checkOutput("incwrap_reg0", 32'(reg0), 32'h00);
      checkFlags("incwrap", 1, 1, 0);

      // Increment 0x7F gives signed overflow.
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd1, 8'h7F);
      applyStimulus(1, 2'd1, 2'd0, 4'h4, 0, 1, 0, 0, 2'd0, 8'h00);
      checkOutput("incovf_reg1", 32'(reg1), 32'h80);
      checkFlags("incovf", 0, 0, 1);

      // Pass B copies REG1 into REG2 and leaves the flags alone.
      applyStimulus(1, 2'd0, 2'd1, 4'h1, 0, 0, 1, 0, 2'd0, 8'h00);
      checkOutput("passb_reg2", 32'(reg2), 32'h80);
      checkOutput("passb_result", 32'(result), 32'h80);
      checkFlags("passb", 0, 0, 1);

      // 03 - 05 borrows.
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd0, 8'h03);
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd1, 8'h05);
      applyStimulus(1, 2'd0, 2'd1, 4'h3, 0, 0, 1, 0, 2'd0, 8'h00);
      checkOutput("sub_reg2", 32'(reg2), 32'hFE);
      checkFlags("sub", 0, 1, 0);

      // REG2 = REG2 + REG2 reads the old value: FE+FE = 1FC.
      applyStimulus(1, 2'd2, 2'd2, 4'h2, 0, 0, 1, 0, 2'd0, 8'h00);
      checkOutput("rbw_reg2", 32'(reg2), 32'hFC);
      checkFlags("rbw", 0, 1, 0);

      // XOR into REG0 and REG1 together: 03 ^ 05 = 06.
      applyStimulus(1, 2'd0, 2'd1, 4'h8, 1, 1, 0, 0, 2'd0, 8'h00);
      checkOutput("xor_reg0", 32'(reg0), 32'h06);
      checkOutput("xor_reg1", 32'(reg1), 32'h06);
      checkFlags("xor", 0, 0, 0);

      // Four back-to-back increments from zero.
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd0, 8'h00);
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 1, 2'd1, 8'h05);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, 2'd0, 2'd0, 4'h4, 1, 0, 0, 0, 2'd0, 8'h00);
         checkOutput($sformatf("b2b_reg0_%0d", i), 32'(reg0), 32'(i));
         checkOutput($sformatf("b2b_out_valid_%0d", i), 32'(out_valid), 32'h1);
      end

      // NOP subtract 04-05 with no save bits: flags only.
      applyStimulus(1, 2'd0, 2'd1, 4'h3, 0, 0, 0, 0, 2'd0, 8'h00);
      checkOutput("nop_result", 32'(result), 32'hFF);
      checkOutput("nop_reg0", 32'(reg0), 32'h04);
      checkFlags("nop", 0, 1, 0);

      // Illegal code colliding with a load of REG1.
      applyStimulus(1, 2'd0, 2'd1, 4'hC, 1, 1, 1, 1, 2'd1, 8'hAA);
      checkOutput("coll_ld_drop", 32'(ld_drop), 32'h1);
      checkOutput("coll_illegal", 32'(illegal), 32'h1);
      checkOutput("coll_out_valid", 32'(out_valid), 32'h1);
      checkOutput("coll_result", 32'(result), 32'h00);
      checkOutput("coll_reg1", 32'(reg1), 32'h05);
      checkOutput("coll_reg0", 32'(reg0), 32'h04);
      checkFlags("coll", 0, 1, 0);

      // Load with no target collides with a legal AND of constants.
      applyStimulus(1, 2'd3, 2'd3, 4'h6, 0, 0, 0, 1, 2'd3, 8'h11);
      checkOutput("coll3_ld_drop", 32'(ld_drop), 32'h1);
      checkOutput("coll3_illegal", 32'(illegal), 32'h0);
      checkFlags("coll3", 1, 0, 0);

      // in_valid low ignores the control word; ld_sel=3 load changes nothing.
      applyStimulus(0, 2'd0, 2'd0, 4'h4, 1, 1, 1, 1, 2'd3, 8'h99);
      checkOutput("inv0_out_valid", 32'(out_valid), 32'h0);
      checkOutput("inv0_ld_drop", 32'(ld_drop), 32'h0);
      checkOutput("inv0_illegal", 32'(illegal), 32'h0);
      checkOutput("inv0_reg0", 32'(reg0), 32'h04);
      checkOutput("inv0_reg1", 32'(reg1), 32'h05);
      checkOutput("inv0_reg2", 32'(reg2), 32'hFC);
      checkOutput("inv0_result", 32'(result), 32'h00);

      // Reset overrides an in-flight instruction.
      reset = 1'b1;
      applyStimulus(1, 2'd0, 2'd0, 4'h4, 1, 0, 0, 0, 2'd0, 8'h00);
      reset = 1'b0;
      applyStimulus(0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
      checkOutput("midrst_reg0", 32'(reg0), 32'h00);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
      checkFlags("midrst", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ev22_exec.md
# ev22_exec

Execute stage of the EV22 core, directly downstream of the instruction decoder. It consumes the decoder's per-instruction control word (`sel_a`, `sel_b`, `alu`, `save0..2`) and holds the three general registers REG0–REG2. It runs the selected ALU operation and writes the result back to the enabled registers. It also keeps status flags and provides a side-load port so the registers can be initialised before a program runs.

## Interface
- `WIDTH`, default 8: data width of registers, ALU and result.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: the control word is valid this cycle.
- `sel_a` input 2: operand A source. 0=REG0, 1=REG1, 2=REG2, 3=constant 0.
- `sel_b` input 2: operand B source, same encoding as `sel_a`.
- `alu` input 4: ALU operation code (see Operation).
- `save0`, `save1`, `save2` input 1 each: write the result to REG0/REG1/REG2.
- `ld_en` input 1: side-load request.
- `ld_sel` input 2: side-load target. 0..2 select REG0..REG2; 3 = no target (ignored).
- `ld_data` input WIDTH: side-load value.
- `reg0`, `reg1`, `reg2` output WIDTH each: current register contents.
- `result` output WIDTH: registered ALU result of the last executed instruction.
- `out_valid` output 1: one-cycle pulse; `result`/`illegal` correspond to the instruction issued on the previous cycle.
- `illegal` output 1: registered; the last executed `alu` code was unsupported.
- `flag_z`, `flag_c`, `flag_v` output 1 each: zero, carry/borrow and signed-overflow flags.
- `ld_drop` output 1: one-cycle pulse; a side-load was discarded because of a collision.

## Operation
- ALU codes:
  - 0000: pass A.
  - 0001: pass B.
  - 0010: A+B.
  - 0011: A−B.
  - 0100: A+1.
  - 0101: A−1.
  - 0110: A&B.
  - 0111: A|B.
  - 1000: A^B.
  - 1001: ~A.
  - 1010–1111: illegal.
- Arithmetic is computed at WIDTH+1 bits; the result is truncated to WIDTH, i.e. it wraps modulo 2^WIDTH.
- Flags update only on a valid legal instruction whose code is not 0000/0001:
  - `flag_z` = (result == 0).
  - Add/inc: `flag_c` = carry-out.
  - Sub/dec: `flag_c` = borrow, i.e. A < subtrahend unsigned.
  - Logic ops: `flag_c` = 0 and `flag_v` = 0.
  - Add/sub/inc/dec: `flag_v` = two's-complement signed overflow.
- Codes 0000/0001 leave the flags unchanged.
- Writeback: on `in_valid` with a legal code, every register whose `saveN`=1 takes the result. Several save bits may be set together. With all save bits 0, nothing is written (a NOP).
- Illegal code:
  - No register write and no flag change.
  - `out_valid`=1, `illegal`=1 and `result`=0 on the next cycle.
- `in_valid`=0: control inputs are ignored, no state changes, and `out_valid`=0 next cycle.
- Side-load:
  - With `ld_en`=1 and no valid instruction, `ld_data` is written to the target register.
  - With `ld_en` and `in_valid` both asserted, the instruction has priority and the load is discarded entirely; `ld_drop` pulses next cycle, even when the load target differs from the save targets.
  - A discarded load with `ld_sel`=3 also raises `ld_drop`.
- Operands are read combinationally from the current register contents. Read-before-write applies within a cycle: an instruction that reads and writes the same register uses the old value.

## Timing
- Reset (synchronous, on the `clk` edge with `reset`=1) clears REG0–REG2, `result`, `out_valid`, `illegal`, `ld_drop`, `flag_z`, `flag_c` and `flag_v` to 0.
- `reset` overrides `in_valid` and `ld_en` in the same cycle; an instruction in flight is lost and `out_valid` stays 0.
- Latency:
  - An instruction issued in cycle N updates the registers and flags at the end of cycle N; the new values are visible from cycle N+1.
  - `result` and `out_valid` appear in cycle N+1.
- Throughput is one instruction per cycle. Back-to-back dependent instructions see the updated registers with no stall and no hazard logic.
- `out_valid`, `ld_drop` and `illegal` are single-cycle pulses that are not held. `illegal` is valid only while `out_valid`=1.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1 and `ld_en`=1 → after release, all registers, flags and pulse outputs read 0.
- Add: side-load REG0=0x05 and REG1=0x03, then issue `sel_a`=0, `sel_b`=1, `alu`=0010, `save2`=1 → next cycle REG2=0x08, `result`=0x08, `out_valid`=1, Z=0, C=0, V=0.
- Wrap/flags:
  - With REG0=0xFF, issue `alu`=0100, `save0`=1 → REG0=0x00, Z=1, C=1, V=0.
  - Then with REG1=0x7F, issue `sel_a`=1, `alu`=0100, `save1`=1 → REG1=0x80, V=1, C=0, Z=0.
- Subtract borrow: with REG0=0x03 and REG1=0x05, issue `alu`=0011, `save2`=1 → REG2=0xFE, C=1, Z=0, V=0.
- Back-to-back: starting from REG0=0, issue four consecutive `alu`=0100/`save0` instructions → REG0 counts 1, 2, 3, 4 on consecutive cycles, with `out_valid` high for 4 cycles.
- Collision and illegal:
  - `ld_en` (REG1←0xAA) together with a valid `alu`=1100 → `ld_drop`=1, `illegal`=1 and `out_valid`=1 next cycle.
  - REG1 and the flags remain unchanged.
